// File: rtl/pipe_pkg.sv
// Shared defaults, LFSR constants and frame type for the pipe scroller.
package pipe_pkg;

    localparam int unsigned ROWS_DEF     = 16;
    localparam int unsigned COLS_DEF     = 16;
    localparam int unsigned GAP_DEF      = 4;
    localparam int unsigned SPACING_DEF  = 5;
    localparam int unsigned BIRD_COL_DEF = 2;

    localparam int unsigned LFSR_W = 8;

    // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form: feedback from bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    localparam int unsigned SCORE_W = 8;

    typedef logic [ROWS_DEF-1:0][COLS_DEF-1:0] frame_t;

endpackage

// File: rtl/pipe_scroller_if.sv
// Bus between game control and the pipe scroller; score exists only when PIPE_SCORE_EN is defined.
interface pipe_scroller_if #(
    parameter int unsigned ROWS = pipe_pkg::ROWS_DEF,
    parameter int unsigned COLS = pipe_pkg::COLS_DEF
);
    localparam int unsigned RB = $clog2(ROWS);

    logic                      step_lvl;
    logic                      enable;
    logic [RB-1:0]             bird_row;
    logic [ROWS-1:0][COLS-1:0] pipes;
    logic                      step_pulse;
    logic                      collide;
`ifdef PIPE_SCORE_EN
    logic [pipe_pkg::SCORE_W-1:0] score;

    modport master (
        output step_lvl, enable, bird_row,
        input  pipes, step_pulse, collide, score
    );

    modport slave (
        input  step_lvl, enable, bird_row,
        output pipes, step_pulse, collide, score
    );
`else
    modport master (
        output step_lvl, enable, bird_row,
        input  pipes, step_pulse, collide
    );

    modport slave (
        input  step_lvl, enable, bird_row,
        output pipes, step_pulse, collide
    );
`endif

endinterface

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR that advances one state per strobe; supplies pipe gap positions.
module pipe_lfsr
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] lfsr
);

    logic feedback_c;

    assign feedback_c = ^(lfsr & LFSR_TAPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[LFSR_W-2:0], feedback_c};
        end
    end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling pipe frame: step edge detect, left shift with LFSR-placed gaps, collision flag.
// Optional 8-bit saturating score counter when PIPE_SCORE_EN is defined.
module pipe_scroller
    import pipe_pkg::*;
#(
    parameter int unsigned ROWS     = ROWS_DEF,
    parameter int unsigned COLS     = COLS_DEF,
    parameter int unsigned GAP      = GAP_DEF,
    parameter int unsigned SPACING  = SPACING_DEF,
    parameter int unsigned BIRD_COL = BIRD_COL_DEF
) (
    input  logic          clk,
    input  logic          reset,
    pipe_scroller_if.slave bus
);

    localparam int unsigned RB  = $clog2(ROWS);
    localparam int unsigned SCW = 4;

    if (ROWS < 8 || (ROWS & (ROWS - 1)) != 0) begin : g_bad_rows
        $error("pipe_scroller: ROWS must be a power of two, at least 8");
    end
    if (SPACING < 2 || SPACING > 15) begin : g_bad_spacing
        $error("pipe_scroller: SPACING must lie in 2..15");
    end
    if (BIRD_COL < 1 || BIRD_COL > COLS - 2) begin : g_bad_bird_col
        $error("pipe_scroller: BIRD_COL must lie in 1..COLS-2");
    end
    if (GAP == 0 || GAP >= ROWS) begin : g_bad_gap
        $error("pipe_scroller: GAP must lie in 1..ROWS-1");
    end

    logic                      step_q;
    logic                      step_pulse_c;
    logic                      accept_c;
    logic                      spawn_c;
    logic [SCW-1:0]            space_cnt;
    logic [LFSR_W-1:0]         lfsr;
    logic [RB-1:0]             gap_raw_c;
    logic [RB-1:0]             gap_top_c;
    logic [ROWS-1:0]           new_col_c;
    logic [ROWS-1:0][COLS-1:0] pipes_q;
    logic [ROWS-1:0][COLS-1:0] pipes_d;
    logic                      collide_q;
    logic                      unused_lfsr;

    // Reset masks the strobe so nothing reads as a step while reset is held.
    assign step_pulse_c = bus.step_lvl & ~step_q & ~reset;
    assign accept_c     = step_pulse_c & bus.enable & ~collide_q;
    assign spawn_c      = (space_cnt == SCW'(SPACING - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step_lvl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            space_cnt <= '0;
        end else if (accept_c) begin
            space_cnt <= spawn_c ? '0 : space_cnt + SCW'(1);
        end
    end

    pipe_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept_c),
        .lfsr    (lfsr)
    );

    // Only the low bits place the gap; fold the rest so the whole word is consumed.
    assign unused_lfsr = ^lfsr;
    assign gap_raw_c   = lfsr[RB-1:0];
    assign gap_top_c   = (32'(gap_raw_c) <= ROWS - GAP) ? gap_raw_c : gap_raw_c - RB'(GAP);

    // Incoming right-hand column: solid except the gap on a spawn step, blank otherwise.
    always_comb begin
        new_col_c = '0;
        if (spawn_c) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                new_col_c[r] = (r < 32'(gap_top_c)) || (r >= 32'(gap_top_c) + GAP);
            end
        end
    end

    always_comb begin
        pipes_d = pipes_q;
        if (accept_c) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                pipes_d[r] = {new_col_c[r], pipes_q[r][COLS-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipes_q <= '0;
        end else begin
            pipes_q <= pipes_d;
        end
    end

    // Sticky until reset; sampled from the frame currently on display.
    always_ff @(posedge clk) begin
        if (reset) begin
            collide_q <= 1'b0;
        end else begin
            collide_q <= collide_q | pipes_q[bus.bird_row][BIRD_COL];
        end
    end

    assign bus.pipes      = pipes_q;
    assign bus.step_pulse = step_pulse_c;
    assign bus.collide    = collide_q;

`ifdef PIPE_SCORE_EN
    logic [SCORE_W-1:0] score_q;
    logic [ROWS-1:0]    bird_col_c;

    always_comb begin
        bird_col_c = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            bird_col_c[r] = pipes_q[r][BIRD_COL];
        end
    end

    // A pipe counts as passed when it leaves the bird column on an accepted step.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else if (accept_c && (|bird_col_c) && (score_q != {SCORE_W{1'b1}})) begin
            score_q <= score_q + SCORE_W'(1);
        end
    end

    assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomized bench for pipe_scroller against a pipe-list reference model; score checks need PIPE_SCORE_EN.
module tb_pipe_scroller;
    import pipe_pkg::*;

    localparam int unsigned ROWS     = ROWS_DEF;
    localparam int unsigned COLS     = COLS_DEF;
    localparam int unsigned GAP      = GAP_DEF;
    localparam int unsigned SPACING  = SPACING_DEF;
    localparam int unsigned BIRD_COL = BIRD_COL_DEF;
    localparam int unsigned RB       = $clog2(ROWS);
    localparam int unsigned FW       = ROWS * COLS;

    typedef struct {
        int col;
        int gap;
    } mpipe_t;

    logic clk = 1'b0;
    logic reset;

    pipe_scroller_if #(.ROWS(ROWS), .COLS(COLS)) bif ();

    pipe_scroller #(
        .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .SPACING(SPACING), .BIRD_COL(BIRD_COL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a list of pipes (column, gap top) rather than a bit frame.
    mpipe_t      mq[$];
    logic [7:0]  m_lfsr;
    int          m_nacc;
    bit          m_step_q;
    bit          m_collide;
    int          m_score;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int gap_of(input logic [7:0] l);
        int r;
        r = int'(l) % int'(ROWS);
        return (r <= int'(ROWS - GAP)) ? r : r - int'(GAP);
    endfunction

    function automatic logic [FW-1:0] render();
        logic [FW-1:0] f;
        f = '0;
        foreach (mq[i]) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                if (r < mq[i].gap || r >= mq[i].gap + int'(GAP)) f[r * int'(COLS) + mq[i].col] = 1'b1;
            end
        end
        return f;
    endfunction

    function automatic int pipe_at(input int col);
        foreach (mq[i]) if (mq[i].col == col) return i;
        return -1;
    endfunction

    function automatic logic [ROWS-1:0] col_bits(input logic [FW-1:0] f, input int c);
        logic [ROWS-1:0] v;
        for (int r = 0; r < int'(ROWS); r++) v[r] = f[r * int'(COLS) + c];
        return v;
    endfunction

    function automatic logic [FW-1:0] col_mask(input int c);
        logic [FW-1:0] m;
        m = '0;
        for (int r = 0; r < int'(ROWS); r++) m[r * int'(COLS) + c] = 1'b1;
        return m;
    endfunction

    function automatic int first_zero(input logic [ROWS-1:0] v);
        for (int r = 0; r < int'(ROWS); r++) if (!v[r]) return r;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_lfsr    = LFSR_SEED;
            m_nacc    = 0;
            m_step_q  = 1'b0;
            m_collide = 1'b0;
            m_score   = 0;
        end else begin
            bit pulse;
            bit acc;
            int k;
            int b;
            pulse = bif.step_lvl && !m_step_q;
            acc   = pulse && bif.enable && !m_collide;
            k     = pipe_at(int'(BIRD_COL));
            b     = int'(bif.bird_row);
            if (acc) begin
                if (k >= 0 && m_score < 255) m_score++;
                foreach (mq[i]) mq[i].col--;
                if (mq.size() > 0 && mq[0].col < 0) void'(mq.pop_front());
                if (m_nacc % int'(SPACING) == int'(SPACING) - 1)
                    mq.push_back('{int'(COLS) - 1, gap_of(m_lfsr)});
                m_nacc++;
                m_lfsr = lfsr_next(m_lfsr);
            end
            if (k >= 0 && (b < mq_gap_saved(k, acc) || b >= mq_gap_saved(k, acc) + int'(GAP))) m_collide = 1'b1;
            m_step_q = bif.step_lvl;
        end
    end

    // Gap of the pipe that sat in the bird column before this edge's shift.
    int hit_gap;
    function automatic int mq_gap_saved(input int k, input bit shifted);
        return shifted ? hit_gap : mq[k].gap;
    endfunction
    always @(negedge clk) begin
        int k;
        k = pipe_at(int'(BIRD_COL));
        hit_gap = (k >= 0) ? mq[k].gap : 0;
    end

    bit chk_en = 1'b0;
    int pulse_cnt = 0;
    int dbl_cnt = 0;
    bit prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("frame", bif.pipes, render());
            check_eq("collide", FW'(bif.collide), FW'(m_collide));
            check_eq("step_pulse", FW'(bif.step_pulse), FW'(bif.step_lvl && !m_step_q && !reset));
`ifdef PIPE_SCORE_EN
            check_eq("score", FW'(bif.score), FW'(m_score));
`endif
        end
        if (bif.step_pulse) pulse_cnt++;
        if (bif.step_pulse && prev_pulse) dbl_cnt++;
        prev_pulse = bif.step_pulse;
    end

    int steer = 0;

    function automatic logic [RB-1:0] steer_row();
        int best;
        best = -1;
        foreach (mq[i]) if (mq[i].col >= int'(BIRD_COL) && (best < 0 || mq[i].col < mq[best].col)) best = i;
        if (best < 0) return bif.bird_row;
        if (steer == 1) return RB'(mq[best].gap);
        return RB'((mq[best].gap + int'(GAP)) % int'(ROWS));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (steer != 0) bif.bird_row = steer_row();
    endtask

    task automatic step_edge(input int hi, input int lo);
        bif.step_lvl = 1'b1;
        repeat (hi) tick();
        bif.step_lvl = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [FW-1:0]   fsnap;
        logic [7:0]      lref;
        logic [7:0]      lsnap;
        logic [ROWS-1:0] cb;
        int              ssnap;
        int              psnap;
        int              g;

        reset        = 1'b1;
        bif.step_lvl = 1'b1;
        bif.enable   = 1'b1;
        bif.bird_row = '0;
        tick();
        tick();
        settle();
        check_eq("pulse_in_reset", FW'(bif.step_pulse), '0);
        check_eq("reset_frame", bif.pipes, '0);
        check_eq("reset_collide", FW'(bif.collide), '0);
        bif.step_lvl = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk_en = 1'b1;

        // Four steps: pulses only, no pipes yet.
        pulse_cnt = 0;
        dbl_cnt   = 0;
        for (int i = 0; i < 4; i++) begin
            step_edge(3, 2);
            settle();
            check_eq("empty_frame", bif.pipes, '0);
        end
        check_eq("pulse_count4", FW'(pulse_cnt), FW'(4));
        check_eq("pulse_width", FW'(dbl_cnt), '0);
        check_eq("space_cnt4", FW'(dut.space_cnt), FW'(4));

        // Fifth step spawns the first pipe in the rightmost column.
        step_edge(1, 2);
        settle();
        lref = LFSR_SEED;
        repeat (4) lref = lfsr_next(lref);
        cb = col_bits(bif.pipes, int'(COLS) - 1);
        g  = first_zero(cb);
        check_eq("spawn_zero_rows", FW'(int'(ROWS) - $countones(cb)), FW'(GAP));
        check_eq("spawn_gap_top", FW'(g), FW'(gap_of(lref)));
        check_eq("gap_in_range", FW'(g <= int'(ROWS - GAP)), FW'(1));
        check_eq("spawn_only_last", bif.pipes & ~col_mask(int'(COLS) - 1), '0);
        repeat (4) step_edge(2, 1);
        settle();
        check_eq("moved_col11", col_bits(bif.pipes, int'(COLS) - 5), cb);
        check_eq("moved_only_col11", bif.pipes & ~col_mask(int'(COLS) - 5), '0);

        // A long high level is one step.
        psnap = pulse_cnt;
        bif.step_lvl = 1'b1;
        repeat (1000) tick();
        bif.step_lvl = 1'b0;
        tick();
        tick();
        settle();
        check_eq("long_high_pulses", FW'(pulse_cnt - psnap), FW'(1));
        check_eq("long_high_col10", col_bits(bif.pipes, int'(COLS) - 6), cb);

        // Disabled steps hold everything; enabling mid-high does not step.
        fsnap = render();
        lsnap = m_lfsr;
        ssnap = m_nacc % int'(SPACING);
        bif.enable = 1'b0;
        repeat (3) step_edge(2, 2);
        settle();
        check_eq("disabled_frame", bif.pipes, fsnap);
        check_eq("disabled_lfsr", FW'(dut.u_lfsr.lfsr), FW'(lsnap));
        check_eq("disabled_space", FW'(dut.space_cnt), FW'(ssnap));
        bif.step_lvl = 1'b1;
        tick();
        tick();
        bif.enable = 1'b1;
        repeat (3) tick();
        settle();
        check_eq("reenable_high_frame", bif.pipes, fsnap);
        bif.step_lvl = 1'b0;
        tick();
        step_edge(2, 2);
        settle();
        check_eq("reenable_step_space", FW'(dut.space_cnt), FW'((ssnap + 1) % int'(SPACING)));

        // Random play with the bird kept in the gaps.
        steer = 1;
        tick();
        for (int i = 0; i < 80; i++) begin
            bif.enable = ($urandom_range(0, 9) != 0);
            step_edge(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end
        bif.enable = 1'b1;
        settle();
        check_eq("no_collide_steered", FW'(bif.collide), '0);

        // Steer into a pipe and wait for the collision.
        steer = 2;
        tick();
        for (int i = 0; i < 100 && !bif.collide; i++) step_edge(1, int'($urandom_range(1, 3)));
        settle();
        check_eq("collide_seen", FW'(bif.collide), FW'(1));
        fsnap = render();
        psnap = m_score;
        steer = 0;
        bif.bird_row = RB'($urandom_range(0, ROWS - 1));
        repeat (3) step_edge(2, 2);
        settle();
        check_eq("frozen_frame", bif.pipes, fsnap);
        check_eq("frozen_collide", FW'(bif.collide), FW'(1));
`ifdef PIPE_SCORE_EN
        check_eq("frozen_score", FW'(bif.score), FW'(psnap));
`endif

        do_reset();
        settle();
        check_eq("rst2_frame", bif.pipes, '0);
        check_eq("rst2_collide", FW'(bif.collide), '0);
        check_eq("rst2_space", FW'(dut.space_cnt), '0);
        check_eq("rst2_lfsr", FW'(dut.u_lfsr.lfsr), FW'(LFSR_SEED));

`ifdef PIPE_SCORE_EN
        // Three pipes through the bird column, then run on to saturation.
        steer = 1;
        tick();
        for (int i = 0; i < 3 * int'(SPACING) + int'(COLS) - int'(BIRD_COL); i++) step_edge(1, 1);
        settle();
        check_eq("score_three", FW'(bif.score), FW'(3));
        for (int i = 0; i < 260 * int'(SPACING); i++) step_edge(1, 1);
        settle();
        check_eq("score_saturate", FW'(bif.score), FW'(255));
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
